writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback datapath for the 5-stage MIPS pipeline.
//  Captures memory-stage results, extracts and sign/zero-extends sub-word load data,
//  selects the ALU, load or link (PC+8) result, and drives the register-file write port.
//  Adds stall/flush control and a load-data hold buffer so a stalled W stage never loses memory data.
// PARAMETERS
//  DATA_W      32  datapath width; legal values are 32 or 64.
//  REG_ADDR_W  5   register-file address width.
//  CNT_W       32  width of the retire counter (used only with WB_RETIRE_CNT_EN).
// PORTS
//  clk              in   1            single clock; all state updates on the rising edge.
//  rst_n            in   1            asynchronous, active-low reset.
//  valid_m          in   1            the M-stage instruction is valid.
//  ctrl_m           in   wb_ctrl_t    {reg_we, sel[1:0], load_type[2:0]}.
//  waddr_m          in   REG_ADDR_W   destination register.
//  alu_result_m     in   DATA_W       ALU result; its low bits are the load byte offset.
//  pc_plus8_m       in   DATA_W       link value for JAL/JALR/BGEZAL.
//  stall_w          in   1            hold the W register contents.
//  flush_w          in   1            squash the instruction entering W.
//  mem_rdata_w      in   DATA_W       synchronous data-memory read data, valid in the W cycle.
//  reg_we_w         out  1            register-file write enable.
//  reg_waddr_w      out  REG_ADDR_W   register-file write address.
//  reg_wdata_w      out  DATA_W       register-file write data; also the forwarding source.
//  retire_cnt_w     out  CNT_W        retired-instruction count (WB_RETIRE_CNT_EN only).
// BEHAVIOUR
//  - Reset: the W register is cleared, so valid=0 and ctrl, waddr and data are all 0.
//    After reset, reg_we_w=0, reg_waddr_w=0, reg_wdata_w=0, retire_cnt_w=0 and hold_vld=0.
//  - Latency: M inputs are sampled on the edge with !stall_w. Outputs are combinational
//    from the W register and appear in the next cycle.
//  - Register update priority:
//    1. flush_w: valid<=0, other fields <=0. Flush wins over stall.
//    2. stall_w: all fields hold.
//    3. otherwise: load the M-stage inputs.
//  - Hold buffer: on the first stalled cycle with a valid load in W, mem_rdata_w is captured
//    into hold_data and hold_vld is set. While hold_vld=1, the load path uses hold_data
//    instead of mem_rdata_w. hold_vld clears on the first non-stalled edge, or on flush.
//  - Load extraction (little-endian; off = alu_result[BYTE_OFF_W-1:0],
//    BYTE_OFF_W = $clog2(DATA_W/8)):
//    - LW=0: 32-bit word at off[BYTE_OFF_W-1:2]; sign-extended when DATA_W=64.
//    - LB=1 / LBU=2: byte at off; sign- / zero-extended.
//    - LH=3 / LHU=4: halfword at off[BYTE_OFF_W-1:1]; off[0] is ignored (no alignment trap).
//    - LD=5: full width, legal only with DATA_W=64. With DATA_W=32 it behaves as LW.
//    - Codes 6-7 behave as LW.
//  - Result select by sel: 0 = ALU, 1 = load, 2 = PC+8, 3 = ALU (reserved).
//  - reg_we_w = valid & ctrl.reg_we & (waddr != 0). A write to $0 is never issued.
//  - reg_waddr_w and reg_wdata_w are driven even when reg_we_w=0 (don't-care to consumers).
// CONFIGURATION
//  WB_RETIRE_CNT_EN
//   - Defined: retire_cnt_w increments by 1 on every edge where valid & !stall_w & !flush_w,
//     counting every retired instruction, write or not. It wraps modulo 2^CNT_W and resets to 0.
//   - Undefined: the counter logic is absent and retire_cnt_w is tied to 0.
// STRUCTURE
//  - wb_pkg: wb_ctrl_t struct, wb_sel_e enum (ALU/MEM/LINK), load_type_e enum (LW..LD),
//    and the helper function byte_off_w(DATA_W).
//  - Sub-module load_align: combinational block (rdata, off, load_type) -> extended data,
//    parametrised by DATA_W.
//  - Top level holds the W register, hold buffer, result mux, write-enable gating and counter.
// TESTING
//  1. Reset then release:
//     - Drive valid_m=1, sel=ALU, waddr=5, alu=0x1234.
//     - Next cycle: reg_we_w=1, waddr=5, wdata=0x0000_1234.
//  2. LB off=3 and LHU off=2 with mem_rdata=0x80FF_7F01:
//     - LB -> wdata=0xFFFF_FF80.
//     - LHU -> wdata=0x0000_80FF.
//  3. Load in W, stall_w=1 for 3 cycles, mem_rdata changes to 0xDEAD_BEEF after the first cycle
//     (word load, sel=MEM):
//     - wdata keeps the originally captured word throughout the stall.
//  4. flush_w=1 together with stall_w=1 while a valid write is in W:
//     - Next cycle: reg_we_w=0, waddr=0.
//     - The hold buffer is cleared.
//  5. waddr_m=0 with reg_we=1 -> reg_we_w=0.
//     sel=LINK with pc_plus8=0x0040_0008 -> wdata=0x0040_0008.
//  6. WB_RETIRE_CNT_EN defined:
//     - 10 valid instructions with 2 stall cycles and 1 flush -> retire_cnt_w=9.
//     - Preload near wrap with CNT_W=4 -> 15 then 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the MEM/WB writeback stage.
//   wb_sel_e    : result source select (ALU / load / link).
//   load_type_e : sub-word load encodings; codes 6-7 are treated as LW.
//   wb_ctrl_t   : control bundle carried from M into W.
//   byte_off_w  : number of byte-offset bits for a given datapath width.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4,
        LT_LD  = 3'd5
    } load_type_e;

    typedef struct packed {
        logic       reg_we;
        wb_sel_e    sel;
        load_type_e load_type;
    } wb_ctrl_t;

    function automatic int unsigned byte_off_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/writeback_stage_load_align.sv
// Little-endian sub-word load extraction and sign/zero extension.
//   i_rdata     : raw data-memory word (DATA_W bits)
//   i_off       : byte offset within the word
//   i_load_type : load encoding (LW, LB, LBU, LH, LHU, LD; others act as LW)
//   o_data      : extracted, extended load result
module writeback_stage_load_align
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]             i_rdata,
    input  logic [byte_off_w(DATA_W)-1:0] i_off,
    input  load_type_e                    i_load_type,
    output logic [DATA_W-1:0]             o_data
);

    localparam int unsigned BOW = byte_off_w(DATA_W);

    // Clearing the low offset bits aligns halfword/word selection (off[0] is ignored for halves).
    logic [BOW-1:0] w_half_off;
    logic [BOW-1:0] w_word_off;
    logic [7:0]     w_byte;
    logic [15:0]    w_half;
    logic [31:0]    w_word;

    assign w_half_off = i_off & ~BOW'(1);
    assign w_word_off = i_off & ~BOW'(3);
    assign w_byte     = 8'(i_rdata >> {i_off, 3'b000});
    assign w_half     = 16'(i_rdata >> {w_half_off, 3'b000});
    assign w_word     = 32'(i_rdata >> {w_word_off, 3'b000});

    // Extension select; the full-width load only exists on a 64-bit datapath.
    always_comb begin
        o_data = DATA_W'($signed(w_word));
        case (i_load_type)
            LT_LB:   o_data = DATA_W'($signed(w_byte));
            LT_LBU:  o_data = DATA_W'(w_byte);
            LT_LH:   o_data = DATA_W'($signed(w_half));
            LT_LHU:  o_data = DATA_W'(w_half);
            LT_LD:   if (DATA_W == 64) o_data = i_rdata;
            default: o_data = DATA_W'($signed(w_word));
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback datapath.
// Captures M-stage results, holds load data across stalls, selects ALU / load / PC+8,
// and drives the register-file write port (also the forwarding source).
// Optional feature macro: WB_RETIRE_CNT_EN enables the retired-instruction counter;
// without it retire_cnt_w is tied to 0.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   valid_m, ctrl_m       : M-stage valid and control bundle
//   waddr_m               : destination register
//   alu_result_m          : ALU result (low bits are the load byte offset)
//   pc_plus8_m            : link value
//   stall_w, flush_w      : hold / squash the W register (flush wins)
//   mem_rdata_w           : synchronous memory read data, valid in the W cycle
//   reg_we_w/waddr/wdata  : register-file write port
//   retire_cnt_w          : retired-instruction count
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_m,
    input  wb_ctrl_t              ctrl_m,
    input  logic [REG_ADDR_W-1:0] waddr_m,
    input  logic [DATA_W-1:0]     alu_result_m,
    input  logic [DATA_W-1:0]     pc_plus8_m,
    input  logic                  stall_w,
    input  logic                  flush_w,
    input  logic [DATA_W-1:0]     mem_rdata_w,
    output logic                  reg_we_w,
    output logic [REG_ADDR_W-1:0] reg_waddr_w,
    output logic [DATA_W-1:0]     reg_wdata_w,
    output logic [CNT_W-1:0]      retire_cnt_w
);

    localparam int unsigned BOW = byte_off_w(DATA_W);

    logic                  r_valid;
    wb_ctrl_t              r_ctrl;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]     r_alu;
    logic [DATA_W-1:0]     r_pc8;
    logic                  r_hold_vld;
    logic [DATA_W-1:0]     r_hold_data;

    logic [DATA_W-1:0]     w_ld_src;
    logic [DATA_W-1:0]     w_ld_data;
    logic [DATA_W-1:0]     w_wdata;
    logic                  w_is_load;

    // W pipeline register: flush > stall > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_waddr <= '0;
            r_alu   <= '0;
            r_pc8   <= '0;
        end else if (flush_w) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_waddr <= '0;
            r_alu   <= '0;
            r_pc8   <= '0;
        end else if (!stall_w) begin
            r_valid <= valid_m;
            r_ctrl  <= ctrl_m;
            r_waddr <= waddr_m;
            r_alu   <= alu_result_m;
            r_pc8   <= pc_plus8_m;
        end
    end

    assign w_is_load = r_valid && (r_ctrl.sel == WB_SEL_MEM);

    // Memory read data is only valid for one cycle; capture it on the first stalled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
        end else if (flush_w || !stall_w) begin
            r_hold_vld  <= 1'b0;
        end else if (w_is_load && !r_hold_vld) begin
            r_hold_vld  <= 1'b1;
            r_hold_data <= mem_rdata_w;
        end
    end

    assign w_ld_src = r_hold_vld ? r_hold_data : mem_rdata_w;

    writeback_stage_load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .i_rdata     (w_ld_src),
        .i_off       (r_alu[BOW-1:0]),
        .i_load_type (r_ctrl.load_type),
        .o_data      (w_ld_data)
    );

    // Result select; the reserved code falls back to the ALU result.
    always_comb begin
        w_wdata = r_alu;
        case (r_ctrl.sel)
            WB_SEL_MEM:  w_wdata = w_ld_data;
            WB_SEL_LINK: w_wdata = r_pc8;
            default:     w_wdata = r_alu;
        endcase
    end

    assign reg_we_w    = r_valid && r_ctrl.reg_we && (r_waddr != '0);
    assign reg_waddr_w = r_waddr;
    assign reg_wdata_w = w_wdata;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retire_cnt;

    // Counts every instruction leaving W, whether or not it writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (r_valid && !stall_w && !flush_w) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign retire_cnt_w = r_retire_cnt;
`else
    assign retire_cnt_w = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard testbench for writeback_stage (DATA_W=32, CNT_W=4).
module tb_writeback_stage;
    import wb_pkg::*;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  valid_m;
    wb_ctrl_t              ctrl_m;
    logic [REG_ADDR_W-1:0] waddr_m;
    logic [DATA_W-1:0]     alu_result_m;
    logic [DATA_W-1:0]     pc_plus8_m;
    logic                  stall_w;
    logic                  flush_w;
    logic [DATA_W-1:0]     mem_rdata_w;
    logic                  reg_we_w;
    logic [REG_ADDR_W-1:0] reg_waddr_w;
    logic [DATA_W-1:0]     reg_wdata_w;
    logic [CNT_W-1:0]      retire_cnt_w;

    writeback_stage #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_m      (valid_m),
        .ctrl_m       (ctrl_m),
        .waddr_m      (waddr_m),
        .alu_result_m (alu_result_m),
        .pc_plus8_m   (pc_plus8_m),
        .stall_w      (stall_w),
        .flush_w      (flush_w),
        .mem_rdata_w  (mem_rdata_w),
        .reg_we_w     (reg_we_w),
        .reg_waddr_w  (reg_waddr_w),
        .reg_wdata_w  (reg_wdata_w),
        .retire_cnt_w (retire_cnt_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                  we;
        logic [REG_ADDR_W-1:0] waddr;
        logic [DATA_W-1:0]     wdata;
        logic [CNT_W-1:0]      cnt;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference retirement state: is W valid, and how many have retired.
    logic             tb_w_valid = 1'b0;
    logic [CNT_W-1:0] tb_cnt     = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic wb_ctrl_t mk(input logic we, input logic [1:0] sel, input logic [2:0] lt);
        wb_ctrl_t c;
        c.reg_we    = we;
        c.sel       = wb_sel_e'(sel);
        c.load_type = load_type_e'(lt);
        return c;
    endfunction

    // One clock: drive M inputs, push expected W output, advance, apply W-cycle memory data, compare.
    task automatic cyc(input logic v, input wb_ctrl_t c, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [31:0] pc8,
                       input logic st, input logic fl, input logic [31:0] rdata,
                       input logic ewe, input logic [4:0] ewa, input logic [31:0] ewd,
                       input string tag);
        exp_t e;
        valid_m      = v;
        ctrl_m       = c;
        waddr_m      = wa;
        alu_result_m = alu;
        pc_plus8_m   = pc8;
        stall_w      = st;
        flush_w      = fl;
        if (tb_w_valid && !st && !fl) tb_cnt = tb_cnt + CNT_W'(1);
        if (fl)       tb_w_valid = 1'b0;
        else if (!st) tb_w_valid = v;
        e.we    = ewe;
        e.waddr = ewa;
        e.wdata = ewd;
`ifdef WB_RETIRE_CNT_EN
        e.cnt   = tb_cnt;
`else
        e.cnt   = '0;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1 mem_rdata_w = rdata;
        #1;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, ".we"},    64'(reg_we_w),     64'(e.we));
            check_eq({tag, ".waddr"}, 64'(reg_waddr_w),  64'(e.waddr));
            check_eq({tag, ".wdata"}, 64'(reg_wdata_w),  64'(e.wdata));
            check_eq({tag, ".cnt"},   64'(retire_cnt_w), 64'(e.cnt));
        end
    endtask

    localparam logic [1:0] S_ALU = 2'd0, S_MEM = 2'd1, S_LNK = 2'd2, S_RSV = 2'd3;

    initial begin
        logic [4:0]  ra;
        logic [31:0] rd;
        rst_n        = 1'b0;
        valid_m      = 1'b0;
        ctrl_m       = '0;
        waddr_m      = '0;
        alu_result_m = '0;
        pc_plus8_m   = '0;
        stall_w      = 1'b0;
        flush_w      = 1'b0;
        mem_rdata_w  = '0;
        #1;
        check_eq("rst.we",    64'(reg_we_w),     64'(0));
        check_eq("rst.waddr", 64'(reg_waddr_w),  64'(0));
        check_eq("rst.wdata", 64'(reg_wdata_w),  64'(0));
        check_eq("rst.cnt",   64'(retire_cnt_w), 64'(0));
        #11 rst_n = 1'b1;

        // Basic ALU writeback.
        cyc(1, mk(1, S_ALU, 0), 5, 32'h1234, 0, 0, 0, 0, 1, 5, 32'h0000_1234, "alu");

        // Sub-word load extraction from 0x80FF_7F01.
        cyc(1, mk(1, S_MEM, 1), 7,  32'h0000_0103, 0, 0, 0, 32'h80FF_7F01, 1, 7,  32'hFFFF_FF80, "lb3");
        cyc(1, mk(1, S_MEM, 4), 8,  32'h0000_2002, 0, 0, 0, 32'h80FF_7F01, 1, 8,  32'h0000_80FF, "lhu2");
        cyc(1, mk(1, S_MEM, 3), 10, 32'h0000_0003, 0, 0, 0, 32'h80FF_7F01, 1, 10, 32'hFFFF_80FF, "lh3");
        cyc(1, mk(1, S_MEM, 1), 11, 32'h0000_0001, 0, 0, 0, 32'h80FF_7F01, 1, 11, 32'h0000_007F, "lb1");
        cyc(1, mk(1, S_MEM, 2), 12, 32'h0000_0002, 0, 0, 0, 32'h80FF_7F01, 1, 12, 32'h0000_00FF, "lbu2");
        cyc(1, mk(1, S_MEM, 0), 13, 32'h0000_0003, 0, 0, 0, 32'h80FF_7F01, 1, 13, 32'h80FF_7F01, "lw");
        cyc(1, mk(1, S_MEM, 5), 14, 32'h0000_0000, 0, 0, 0, 32'h1357_9BDF, 1, 14, 32'h1357_9BDF, "ld32");
        cyc(1, mk(1, S_MEM, 6), 15, 32'h0000_0001, 0, 0, 0, 32'hCAFE_F00D, 1, 15, 32'hCAFE_F00D, "lt6");

        // Load stalled for 3 cycles while memory data changes.
        cyc(1, mk(1, S_MEM, 0), 9, 0, 0, 0, 0, 32'h1122_3344, 1, 9, 32'h1122_3344, "ldst0");
        for (int i = 0; i < 3; i++)
            cyc(1, mk(1, S_ALU, 0), 20, 32'h77, 0, 1, 0, 32'hDEAD_BEEF, 1, 9, 32'h1122_3344, "stall");
        cyc(1, mk(1, S_ALU, 0), 3, 32'h55, 0, 0, 0, 32'hDEAD_BEEF, 1, 3, 32'h0000_0055, "post");

        // Flush together with stall squashes a valid write.
        cyc(1, mk(1, S_MEM, 0), 4, 0, 0, 0, 0, 32'hAAAA_0001, 1, 4, 32'hAAAA_0001, "fl0");
        cyc(1, mk(1, S_ALU, 0), 21, 32'h9, 0, 1, 0, 32'hBBBB_0002, 1, 4, 32'hAAAA_0001, "fl1");
        cyc(1, mk(1, S_ALU, 0), 22, 32'h9, 0, 1, 1, 32'hCCCC_0003, 0, 0, 32'h0000_0000, "flush");
        cyc(1, mk(1, S_MEM, 0), 6, 0, 0, 0, 0, 32'hCCCC_0004, 1, 6, 32'hCCCC_0004, "after");

        // Write-enable gating, link and reserved select.
        cyc(1, mk(1, S_ALU, 0), 0,  32'hABCD, 0, 0, 0, 0, 0, 0,  32'h0000_ABCD, "r0");
        cyc(1, mk(1, S_LNK, 0), 31, 32'h1, 32'h0040_0008, 0, 0, 0, 1, 31, 32'h0040_0008, "link");
        cyc(1, mk(1, S_RSV, 0), 2,  32'h4321, 32'h8, 0, 0, 0, 1, 2, 32'h0000_4321, "rsv");
        cyc(1, mk(0, S_ALU, 0), 17, 32'h66, 0, 0, 0, 0, 0, 17, 32'h0000_0066, "nowe");
        cyc(0, mk(1, S_ALU, 0), 18, 32'h88, 0, 0, 0, 0, 0, 18, 32'h0000_0088, "inval");

        // Random ALU traffic with sporadic stalls; also wraps the 4-bit retire count.
        for (int i = 0; i < 24; i++) begin
            ra = 5'($urandom_range(0, 31));
            rd = $urandom;
            cyc(1, mk(1, S_ALU, 0), ra, rd, 0, 0, 0, 0, (ra != 0), ra, rd, "rnd");
            if (i % 7 == 3)
                cyc(1, mk(1, S_ALU, 0), 1, 32'h1, 0, 1, 0, 0, (ra != 0), ra, rd, "rndst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
